// File: rtl/multicycle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_pkg
// Shared encodings for the multicycle 16-bit RISC sequencer.
//   - Opcodes (IR[15:12]), the same encoding the control unit decodes.
//   - Stage encodings, which are also the values seen on o_stage.
//   - PC source select encodings driven on o_pc_src.
// ---------------------------------------------------------------------------
package multicycle_sequencer_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_LB   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_ANDI = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_SV   = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_IF   = 3'b001,
    ST_ID   = 3'b010,
    ST_EX   = 3'b011,
    ST_MEM  = 3'b100,
    ST_WB   = 3'b101
  } stage_t;

  localparam logic [1:0] PCS_INC = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_RET = 2'b11;

  // RET reloads the PC from the return register; every other jr-class
  // instruction (JMP) takes the jump target.
  function automatic logic [1:0] jumpSrc(input logic [3:0] op);
    return (op == OP_RET) ? PCS_RET : PCS_JMP;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
// Wrapping up-counter with synchronous clear and count enable.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (count -> 0)
//   i_clr    synchronous clear, wins over i_en
//   i_en     increment by one, wraps modulo 2^W
//   o_count  current count
// ---------------------------------------------------------------------------
module seq_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register: clear has priority so the owner can restart the
  // count in the same cycle it would otherwise have incremented.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
// Moore FSM stepping the multicycle datapath through IDLE/IF/ID/EX/MEM/WB.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_run                  fetch next instruction (sampled in IDLE/completion)
//   i_op                   opcode from the held IR
//   i_branch..i_reg_wr     decoded control flags from the control unit
//   i_br_taken             ALU compare result (used in EX only)
//   i_mem_ready            data memory completion (used in MEM only)
//   o_pc_wr, o_pc_src      PC load enable and source select
//   o_ir_wr, o_rf_wr       IR load enable, register file write strobe
//   o_dmem_rd, o_dmem_wr   data memory requests
//   o_stage                registered current stage
//   o_mem_err              sticky MEM timeout flag
//   o_retired              completed-instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic [3:0]       i_op,
  input  logic             i_branch,
  input  logic             i_store,
  input  logic             i_sv,
  input  logic             i_jr,
  input  logic             i_mem_rd,
  input  logic             i_mem_wr,
  input  logic             i_reg_wr,
  input  logic             i_br_taken,
  input  logic             i_mem_ready,
  output logic             o_pc_wr,
  output logic [1:0]       o_pc_src,
  output logic             o_ir_wr,
  output logic             o_rf_wr,
  output logic             o_dmem_rd,
  output logic             o_dmem_wr,
  output logic [2:0]       o_stage,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_retired
);

  // The wait counter only has to reach WAIT_MAX-1: the abort fires on the
  // edge that would have made it WAIT_MAX.
  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  stage_t            r_stage;
  logic              r_memErr;
  logic [WAIT_W-1:0] w_waitCount;
  logic              w_waitEn;
  logic              w_waitClr;
  logic              w_memAbort;
  logic              w_complete;

  // Timeout and completion detection. An instruction completes in the
  // stage that ends its class path; a MEM timeout never counts as one.
  always_comb begin
    w_memAbort = (r_stage == ST_MEM) && !i_mem_ready && (WAIT_MAX != 0) &&
                 (w_waitCount == WAIT_LAST);
    w_waitEn   = (r_stage == ST_MEM) && !i_mem_ready;
    w_waitClr  = (r_stage != ST_MEM) || i_mem_ready || w_memAbort;
    w_complete = 1'b0;
    case (r_stage)
      ST_ID:   w_complete = i_jr;
      ST_EX:   w_complete = i_branch;
      ST_MEM:  w_complete = i_mem_ready && !i_mem_rd;
      ST_WB:   w_complete = 1'b1;
      default: w_complete = 1'b0;
    endcase
  end

  // State register plus the sticky error flag. Completion decides between
  // fetching again and parking, so i_run is only looked at there and in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage  <= ST_IDLE;
      r_memErr <= 1'b0;
    end else begin
      if (w_memAbort) begin
        r_memErr <= 1'b1;
      end
      if (w_complete) begin
        r_stage <= i_run ? ST_IF : ST_IDLE;
      end else begin
        case (r_stage)
          ST_IDLE: if (i_run) r_stage <= ST_IF;
          ST_IF:   r_stage <= ST_ID;
          ST_ID: begin
            if (i_op == OP_CALL)   r_stage <= ST_WB;
            else if (i_sv)         r_stage <= ST_MEM;
            else                   r_stage <= ST_EX;
          end
          ST_EX: begin
            if (i_mem_rd || i_store) r_stage <= ST_MEM;
            else                     r_stage <= ST_WB;
          end
          ST_MEM: begin
            if (w_memAbort)       r_stage <= ST_IDLE;
            else if (i_mem_ready) r_stage <= ST_WB;
          end
          default: r_stage <= ST_IDLE;
        endcase
      end
    end
  end

  // Per-stage strobes, decoded from the current stage and the flags. They
  // fall to zero the moment reset forces the stage back to IDLE.
  always_comb begin
    o_pc_wr   = 1'b0;
    o_pc_src  = PCS_INC;
    o_ir_wr   = 1'b0;
    o_rf_wr   = 1'b0;
    o_dmem_rd = 1'b0;
    o_dmem_wr = 1'b0;
    case (r_stage)
      ST_IF: begin
        o_ir_wr = 1'b1;
        o_pc_wr = 1'b1;
      end
      ST_ID: begin
        if (i_jr) begin
          o_pc_wr  = 1'b1;
          o_pc_src = jumpSrc(i_op);
        end
      end
      ST_EX: begin
        if (i_branch) begin
          o_pc_wr  = i_br_taken;
          o_pc_src = PCS_BR;
        end
      end
      ST_MEM: begin
        o_dmem_rd = i_mem_rd;
        o_dmem_wr = i_mem_wr;
      end
      ST_WB: begin
        o_rf_wr = i_reg_wr;
        if (i_op == OP_CALL) begin
          o_pc_wr  = 1'b1;
          o_pc_src = PCS_JMP;
        end
      end
      default: ;
    endcase
  end

  seq_counter #(.W(CNT_W)) u_retired (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (1'b0),
    .i_en    (w_complete),
    .o_count (o_retired)
  );

  seq_counter #(.W(WAIT_W)) u_wait (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_waitClr),
    .i_en    (w_waitEn),
    .o_count (w_waitCount)
  );

  assign o_stage   = r_stage;
  assign o_mem_err = r_memErr;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed per-cycle trace of the sequencer. The stimulus process plays the
// control unit (decodes flags from the opcode) and queues the hand-derived
// expected outputs for each cycle; the monitor pops and compares on the
// falling edge. Retired counter is 4 bits so a wrap fits in 16 instructions.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_IF   = 3'b001;
  localparam logic [2:0] S_ID   = 3'b010;
  localparam logic [2:0] S_EX   = 3'b011;
  localparam logic [2:0] S_MEM  = 3'b100;
  localparam logic [2:0] S_WB   = 3'b101;

  localparam logic [3:0] ADD  = 4'b0001;
  localparam logic [3:0] LW   = 4'b0101;
  localparam logic [3:0] SW   = 4'b0111;
  localparam logic [3:0] BEQ  = 4'b1010;
  localparam logic [3:0] JMP  = 4'b1100;
  localparam logic [3:0] CALL = 4'b1101;
  localparam logic [3:0] RET  = 4'b1110;
  localparam logic [3:0] SV   = 4'b1111;

  typedef struct packed {
    logic [2:0] stage;
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       irWr;
    logic       rfWr;
    logic       dRd;
    logic       dWr;
    logic       err;
    logic [3:0] ret;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] op;
  logic       branch, store, sv, jr, memRd, memWr, regWr;
  logic       brTaken, memReady;
  logic       pcWr, irWr, rfWr, dmemRd, dmemWr, memErr;
  logic [1:0] pcSrc;
  logic [2:0] stage;
  logic [3:0] retired;

  exp_t  expQ[$];
  string nameQ[$];
  int    compared;
  int    mismatched;

  multicycle_sequencer #(.CNT_W(4), .WAIT_MAX(15)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (run),
    .i_op        (op),
    .i_branch    (branch),
    .i_store     (store),
    .i_sv        (sv),
    .i_jr        (jr),
    .i_mem_rd    (memRd),
    .i_mem_wr    (memWr),
    .i_reg_wr    (regWr),
    .i_br_taken  (brTaken),
    .i_mem_ready (memReady),
    .o_pc_wr     (pcWr),
    .o_pc_src    (pcSrc),
    .o_ir_wr     (irWr),
    .o_rf_wr     (rfWr),
    .o_dmem_rd   (dmemRd),
    .o_dmem_wr   (dmemWr),
    .o_stage     (stage),
    .o_mem_err   (memErr),
    .o_retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control-unit stand-in: {branch, store, sv, jr, mem_rd, mem_wr, reg_wr}.
  function automatic logic [6:0] decode(input logic [3:0] o);
    logic [6:0] f;
    f = 7'b0;
    case (o)
      4'b1010, 4'b1011: f = 7'b1000000;
      4'b0111:          f = 7'b0100010;
      4'b1111:          f = 7'b0010010;
      4'b1100, 4'b1110: f = 7'b0001000;
      4'b0101, 4'b0110: f = 7'b0000101;
      4'b1101:          f = 7'b0000001;
      default:          f = 7'b0000001;
    endcase
    return f;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue what the
  // outputs must look like for the rest of that cycle.
  task automatic applyStimulus(input string name, input logic rstn, input logic runV,
                               input logic [3:0] opV, input logic brT, input logic mRdy,
                               input logic [2:0] eStage, input logic ePcWr,
                               input logic [1:0] ePcSrc, input logic eIrWr,
                               input logic eRfWr, input logic eDRd, input logic eDWr,
                               input logic eErr, input logic [3:0] eRet);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rstn;
    run      = runV;
    op       = opV;
    {branch, store, sv, jr, memRd, memWr, regWr} = decode(opV);
    brTaken  = brT;
    memReady = mRdy;
    e = '{stage: eStage, pcWr: ePcWr, pcSrc: ePcSrc, irWr: eIrWr, rfWr: eRfWr,
          dRd: eDRd, dWr: eDWr, err: eErr, ret: eRet};
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // pc_src only matters when the PC is actually loaded.
  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a = '{stage: stage, pcWr: pcWr, pcSrc: pcSrc, irWr: irWr, rfWr: rfWr,
          dRd: dmemRd, dWr: dmemWr, err: memErr, ret: retired};
    if (!e.pcWr) begin
      a.pcSrc = 2'b00;
      e.pcSrc = 2'b00;
    end
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got stage=%0d pcWr=%0b pcSrc=%0d irWr=%0b rfWr=%0b dRd=%0b dWr=%0b err=%0b ret=%0d, expected stage=%0d pcWr=%0b pcSrc=%0d irWr=%0b rfWr=%0b dRd=%0b dWr=%0b err=%0b ret=%0d",
               name, a.stage, a.pcWr, a.pcSrc, a.irWr, a.rfWr, a.dRd, a.dWr, a.err, a.ret,
               e.stage, e.pcWr, e.pcSrc, e.irWr, e.rfWr, e.dRd, e.dWr, e.err, e.ret);
    end
  endtask

  // Monitor: compare on every falling edge for which a cycle was queued.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput(nameQ.pop_front(), expQ.pop_front());
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0; run = 1'b0; op = 4'b0; brTaken = 1'b0; memReady = 1'b0;
    {branch, store, sv, jr, memRd, memWr, regWr} = 7'b0;

    //             name         rstn run op  brT rdy  stage  pcW src  irW rfW dRd dWr err ret
    applyStimulus("reset",       0, 0, ADD, 0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("rel_idle",    1, 1, ADD, 0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    // ADD: IF-ID-EX-WB
    applyStimulus("add_if",      1, 1, ADD, 0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd0);
    applyStimulus("add_id",      1, 1, ADD, 0, 0, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("add_ex",      1, 1, ADD, 0, 0, S_EX,   0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("add_wb",      1, 1, ADD, 0, 0, S_WB,   0, 2'd0, 0, 1, 0, 0, 0, 4'd0);
    // LW with three wait cycles
    applyStimulus("lw_if",       1, 1, LW,  0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd1);
    applyStimulus("lw_id",       1, 1, LW,  0, 0, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd1);
    applyStimulus("lw_ex",       1, 1, LW,  0, 0, S_EX,   0, 2'd0, 0, 0, 0, 0, 0, 4'd1);
    applyStimulus("lw_mem0",     1, 1, LW,  0, 0, S_MEM,  0, 2'd0, 0, 0, 1, 0, 0, 4'd1);
    applyStimulus("lw_mem1",     1, 1, LW,  0, 0, S_MEM,  0, 2'd0, 0, 0, 1, 0, 0, 4'd1);
    applyStimulus("lw_mem2",     1, 1, LW,  0, 0, S_MEM,  0, 2'd0, 0, 0, 1, 0, 0, 4'd1);
    applyStimulus("lw_mem3",     1, 1, LW,  0, 1, S_MEM,  0, 2'd0, 0, 0, 1, 0, 0, 4'd1);
    applyStimulus("lw_wb",       1, 1, LW,  0, 0, S_WB,   0, 2'd0, 0, 1, 0, 0, 0, 4'd1);
    // BEQ taken (br_taken also high in ID, where it must be ignored)
    applyStimulus("beqt_if",     1, 1, BEQ, 0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd2);
    applyStimulus("beqt_id",     1, 1, BEQ, 1, 0, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd2);
    applyStimulus("beqt_ex",     1, 1, BEQ, 1, 0, S_EX,   1, 2'd1, 0, 0, 0, 0, 0, 4'd2);
    // BEQ not taken
    applyStimulus("beqn_if",     1, 1, BEQ, 0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd3);
    applyStimulus("beqn_id",     1, 1, BEQ, 0, 0, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd3);
    applyStimulus("beqn_ex",     1, 1, BEQ, 0, 0, S_EX,   0, 2'd1, 0, 0, 0, 0, 0, 4'd3);
    // CALL: IF-ID-WB
    applyStimulus("call_if",     1, 1, CALL,0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd4);
    applyStimulus("call_id",     1, 1, CALL,0, 0, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd4);
    applyStimulus("call_wb",     1, 1, CALL,0, 0, S_WB,   1, 2'd2, 0, 1, 0, 0, 0, 4'd4);
    // RET and JMP: IF-ID
    applyStimulus("ret_if",      1, 1, RET, 0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd5);
    applyStimulus("ret_id",      1, 1, RET, 0, 0, S_ID,   1, 2'd3, 0, 0, 0, 0, 0, 4'd5);
    applyStimulus("jmp_if",      1, 1, JMP, 0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd6);
    applyStimulus("jmp_id",      1, 1, JMP, 0, 0, S_ID,   1, 2'd2, 0, 0, 0, 0, 0, 4'd6);
    // SV zero-wait (mem_ready high in ID must be ignored)
    applyStimulus("sv_if",       1, 1, SV,  0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd7);
    applyStimulus("sv_id",       1, 1, SV,  0, 1, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd7);
    applyStimulus("sv_mem",      1, 1, SV,  0, 1, S_MEM,  0, 2'd0, 0, 0, 0, 1, 0, 4'd7);
    // SW with mem_ready stuck low: 15 MEM cycles then abort to IDLE
    applyStimulus("sw_if",       1, 1, SW,  0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd8);
    applyStimulus("sw_id",       1, 1, SW,  0, 0, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd8);
    applyStimulus("sw_ex",       1, 1, SW,  0, 0, S_EX,   0, 2'd0, 0, 0, 0, 0, 0, 4'd8);
    for (int i = 0; i < 15; i++) begin
      applyStimulus("sw_mem_wait", 1, 1, SW, 0, 0, S_MEM, 0, 2'd0, 0, 0, 0, 1, 0, 4'd8);
    end
    applyStimulus("sw_abort",    1, 0, SW,  0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 1, 4'd8);
    applyStimulus("err_sticky",  1, 0, SW,  0, 1, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 1, 4'd8);
    applyStimulus("err_reset",   0, 0, ADD, 0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("err_rel",     1, 1, ADD, 0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    // 16 ALU instructions wrap the 4-bit counter; run dropped mid-instr once
    for (int i = 0; i < 16; i++) begin
      applyStimulus("wrap_if", 1, 1, ADD, 0, 0, S_IF, 1, 2'd0, 1, 0, 0, 0, 0, 4'(i));
      applyStimulus("wrap_id", 1, (i != 3), ADD, 0, 0, S_ID, 0, 2'd0, 0, 0, 0, 0, 0, 4'(i));
      applyStimulus("wrap_ex", 1, (i != 3), ADD, 0, 0, S_EX, 0, 2'd0, 0, 0, 0, 0, 0, 4'(i));
      applyStimulus("wrap_wb", 1, (i != 15), ADD, 0, 0, S_WB, 0, 2'd0, 0, 1, 0, 0, 0, 4'(i));
    end
    applyStimulus("wrap_idle",   1, 0, ADD, 0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("park_idle",   1, 1, LW,  0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    // Reset asserted in the middle of a MEM wait
    applyStimulus("lw2_if",      1, 1, LW,  0, 0, S_IF,   1, 2'd0, 1, 0, 0, 0, 0, 4'd0);
    applyStimulus("lw2_id",      1, 1, LW,  0, 0, S_ID,   0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("lw2_ex",      1, 1, LW,  0, 0, S_EX,   0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("lw2_mem",     1, 1, LW,  0, 0, S_MEM,  0, 2'd0, 0, 0, 1, 0, 0, 4'd0);
    applyStimulus("rst_in_mem",  0, 1, LW,  0, 0, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("rst_rel",     1, 0, LW,  0, 1, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);
    applyStimulus("stay_idle",   1, 0, LW,  0, 1, S_IDLE, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0);

    repeat (3) @(negedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
